// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction memory boot loader: FSM state encoding,
// frame constants and the running checksum helper.
package imem_boot_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CSUM    = 3'd3,
    ST_RUN     = 3'd4,
    ST_ERROR   = 3'd5
  } state_e;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
  localparam logic [7:0] LEN_256        = 8'h00;
  localparam logic [8:0] LEN_256_COUNT  = 9'd256;

  // 8-bit additive checksum; wraps modulo 256
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] data);
    return acc + data;
  endfunction

endpackage

// File: rtl/imem_boot_loader_timeout.sv
// Inter-byte timeout counter: cleared on demand, counts while enabled and
// saturates at TIMEOUT_CYCLES with expired held high.
module imem_boot_loader_timeout #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_r;

  assign expired = (cnt_r == CNT_W'(TIMEOUT_CYCLES));

  // cycle counter, saturating at the timeout value
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (en && !expired) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader owning the instruction memory port: loads HEADER/LEN/payload frames from
// the UART byte stream, then hands reads to the CPU. Optional checksum: IMEM_BOOT_CHECKSUM_EN.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int          ADDR_W         = 8,
  parameter int          DATA_W         = 8,
  parameter logic [7:0]  HEADER         = HEADER_DEFAULT,
  parameter int          TIMEOUT_CYCLES = 100000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              boot_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [DATA_W-1:0] cpu_instr,
  output logic              cpu_reset,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              load_done,
  output logic              load_err
);

  state_e            state_r, state_nx_s;
  logic [ADDR_W-1:0] ptr_r, ptr_nx_s;
  logic [8:0]        cnt_r, cnt_nx_s;
  logic [7:0]        acc_r, acc_nx_s;
  logic              wr_s;
  logic              we_r;
  logic [ADDR_W-1:0] waddr_r;
  logic [DATA_W-1:0] wdata_r;
  logic              cpu_reset_r, load_done_r, load_err_r;
  logic              in_frame_s, expired_s;

  assign in_frame_s = (state_r == ST_LEN) || (state_r == ST_PAYLOAD) || (state_r == ST_CSUM);

  imem_boot_loader_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .clr     (rx_valid || !in_frame_s),
    .en      (in_frame_s),
    .expired (expired_s)
  );

  // next-state, pointer, count and checksum logic; a received byte beats a timeout
  always_comb begin
    state_nx_s = state_r;
    ptr_nx_s   = ptr_r;
    cnt_nx_s   = cnt_r;
    acc_nx_s   = acc_r;
    wr_s       = 1'b0;
    case (state_r)
      ST_IDLE, ST_ERROR: begin
        if (rx_valid && (rx_data == HEADER)) begin
          state_nx_s = ST_LEN;
          ptr_nx_s   = {ADDR_W{1'b0}};
          acc_nx_s   = 8'h00;
          cnt_nx_s   = 9'd0;
        end else begin
          state_nx_s = state_r;
        end
      end
      ST_LEN: begin
        if (rx_valid) begin
          cnt_nx_s   = (rx_data == LEN_256) ? LEN_256_COUNT : {1'b0, rx_data};
          state_nx_s = ST_PAYLOAD;
        end else if (expired_s) begin
          state_nx_s = ST_ERROR;
        end else begin
          state_nx_s = ST_LEN;
        end
      end
      ST_PAYLOAD: begin
        if (rx_valid) begin
          wr_s     = 1'b1;
          ptr_nx_s = ptr_r + ADDR_W'(1);
          acc_nx_s = csum_add(acc_r, rx_data);
          cnt_nx_s = cnt_r - 9'd1;
          if (cnt_r == 9'd1) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
            state_nx_s = ST_CSUM;
`else
            state_nx_s = ST_RUN;
`endif
          end else begin
            state_nx_s = ST_PAYLOAD;
          end
        end else if (expired_s) begin
          state_nx_s = ST_ERROR;
        end else begin
          state_nx_s = ST_PAYLOAD;
        end
      end
      ST_CSUM: begin
        if (rx_valid) begin
          state_nx_s = (rx_data == acc_r) ? ST_RUN : ST_ERROR;
        end else if (expired_s) begin
          state_nx_s = ST_ERROR;
        end else begin
          state_nx_s = ST_CSUM;
        end
      end
      ST_RUN: begin
        if (boot_req) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // state, frame registers and output flags decoded from the next state
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      ptr_r       <= {ADDR_W{1'b0}};
      cnt_r       <= 9'd0;
      acc_r       <= 8'h00;
      cpu_reset_r <= 1'b1;
      load_done_r <= 1'b0;
      load_err_r  <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      ptr_r       <= ptr_nx_s;
      cnt_r       <= cnt_nx_s;
      acc_r       <= acc_nx_s;
      cpu_reset_r <= (state_nx_s != ST_RUN);
      load_done_r <= (state_nx_s == ST_RUN);
      load_err_r  <= (state_nx_s == ST_ERROR);
    end
  end

  // write register stage; reset drops a write that has not yet been issued
  always_ff @(posedge clock) begin
    if (reset) begin
      we_r    <= 1'b0;
      waddr_r <= {ADDR_W{1'b0}};
      wdata_r <= {DATA_W{1'b0}};
    end else if (wr_s) begin
      we_r    <= 1'b1;
      waddr_r <= ptr_r;
      wdata_r <= DATA_W'(rx_data);
    end else begin
      we_r    <= 1'b0;
      waddr_r <= waddr_r;
      wdata_r <= wdata_r;
    end
  end

  // the final payload write can land in the first RUN cycle, so it keeps the port
  assign mem_addr  = (load_done_r && !we_r) ? cpu_addr : waddr_r;
  assign mem_wdata = wdata_r;
  assign mem_we    = we_r;
  assign cpu_instr = load_done_r ? mem_rdata : {DATA_W{1'b0}};
  assign cpu_reset = cpu_reset_r;
  assign load_done = load_done_r;
  assign load_err  = load_err_r;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader with a behavioural 256x8 memory; adapts its
// frames to IMEM_BOOT_CHECKSUM_EN.
module tb_imem_boot_loader;

  localparam int T_OUT = 40;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       boot_req = 1'b0;
  logic [7:0] cpu_addr = 8'h00;
  logic [7:0] cpu_instr;
  logic       cpu_reset;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic [7:0] mem_rdata;
  logic       load_done;
  logic       load_err;

  logic [7:0] mem [256];
  int checks = 0;
  int errors = 0;

  imem_boot_loader #(
    .ADDR_W         (8),
    .DATA_W         (8),
    .HEADER         (8'hA5),
    .TIMEOUT_CYCLES (T_OUT)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .boot_req  (boot_req),
    .cpu_addr  (cpu_addr),
    .cpu_instr (cpu_instr),
    .cpu_reset (cpu_reset),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = mem[mem_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic boot_pulse();
    boot_req = 1'b1;
    @(posedge clock);
    @(negedge clock);
    boot_req = 1'b0;
  endtask

  initial begin
    // reset and quiet line
    idle(3);
    reset = 1'b0;
    idle(5);
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_load_done", load_done, 0);
    check("rst_load_err", load_err, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_cpu_instr", cpu_instr, 0);

    // three-byte program
    send(8'hA5); send(8'h03); send(8'hC0);
    check("f1_we0", mem_we, 1);
    check("f1_addr0", mem_addr, 8'h00);
    check("f1_wdata0", mem_wdata, 8'hC0);
    send(8'hD7); send(8'h03);
    check("f1_addr2", mem_addr, 8'h02);
`ifdef IMEM_BOOT_CHECKSUM_EN
    send(8'h9A);
`endif
    check("f1_done", load_done, 1);
    check("f1_cpu_reset", cpu_reset, 0);
    idle(1);
    check("f1_mem0", mem[0], 8'hC0);
    check("f1_mem1", mem[1], 8'hD7);
    check("f1_mem2", mem[2], 8'h03);
    cpu_addr = 8'h01;
    #1;
    check("f1_instr", cpu_instr, 8'hD7);
`ifndef IMEM_BOOT_CHECKSUM_EN
    send(8'h9A);
    check("run_rx_ignored_we", mem_we, 0);
    check("run_rx_ignored_done", load_done, 1);
`endif

    // boot_req and header byte in the same RUN cycle: header must be dropped
    rx_data  = 8'hA5;
    rx_valid = 1'b1;
    boot_pulse();
    rx_valid = 1'b0;
    check("boot_done", load_done, 0);
    check("boot_cpu_reset", cpu_reset, 1);
    check("boot_instr", cpu_instr, 0);
    send(8'h01); send(8'h77);
    check("boot_drop_we", mem_we, 0);
    check("boot_drop_done", load_done, 0);

    // 256-byte image, pointer wraps
    send(8'hA5); send(8'h00);
    for (int i = 0; i < 256; i++) begin
      send(8'(i));
      if (i == 0) check("big_addr_first", mem_addr, 8'h00);
    end
    check("big_we_last", mem_we, 1);
    check("big_addr_last", mem_addr, 8'hFF);
`ifdef IMEM_BOOT_CHECKSUM_EN
    check("big_not_done_before_csum", load_done, 0);
    send(8'h80);
`endif
    check("big_done", load_done, 1);
    idle(1);
    check("big_mem255", mem[255], 8'hFF);
    check("big_mem0", mem[0], 8'h00);
    check("big_mem128", mem[128], 8'h80);
    cpu_addr = 8'hFF;
    #1;
    check("big_instr", cpu_instr, 8'hFF);
    boot_pulse();

    // bad checksum (plain RUN when checksum is off)
    send(8'hA5); send(8'h02); send(8'h11); send(8'h22);
`ifdef IMEM_BOOT_CHECKSUM_EN
    send(8'h00);
    check("bad_err", load_err, 1);
    check("bad_cpu_reset", cpu_reset, 1);
    check("bad_done", load_done, 0);
`else
    check("nochk_done", load_done, 1);
    check("nochk_err", load_err, 0);
    boot_pulse();
`endif
    send(8'hA5);
    check("hdr_clears_err", load_err, 0);
    check("hdr_cpu_reset", cpu_reset, 1);

    // timeout inside the payload
    send(8'h04); send(8'h01);
    idle(T_OUT);
    check("tmo_not_yet", load_err, 0);
    idle(1);
    check("tmo_err", load_err, 1);
    check("tmo_cpu_reset", cpu_reset, 1);

    // reset with a payload byte in flight: write dropped, old image kept
    send(8'hA5);
    check("tmo_hdr_clears", load_err, 0);
    send(8'h04);
    reset    = 1'b1;
    rx_data  = 8'h55;
    rx_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset    = 1'b0;
    rx_valid = 1'b0;
    check("rstmid_we", mem_we, 0);
    check("rstmid_err", load_err, 0);
    check("rstmid_cpu_reset", cpu_reset, 1);
    idle(2);
    check("rstmid_mem0", mem[0], 8'h01);
    check("rstmid_we_idle", mem_we, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
